// File: rtl/wb_pkg.sv
// Shared defaults and writeback source encodings for the MEM/WB select stage.
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REGW_DEFAULT = 5;
  localparam int NSRC_DEFAULT = 4;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC4 = 2'd2,
    SRC_IMM = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational NSRC:1 writeback source mux; out-of-range selects give zero data
// and a low in_range flag so the stage can suppress the write.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NSRC = NSRC_DEFAULT,
  parameter int SELW = $clog2(NSRC)
) (
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [SELW-1:0]      sel,
  output logic [XLEN-1:0]      data,
  output logic                 in_range
);

  always_comb begin
    data     = '0;
    in_range = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) begin
        data     = src_data[i*XLEN +: XLEN];
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register driving the register-file write port, with stall,
// flush, x0 suppression and a retired-write counter. WB_BYPASS_EN adds a
// one-entry write history for the WB-to-ID read-after-write case.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NSRC = NSRC_DEFAULT,
  parameter int SELW = $clog2(NSRC),
  parameter int REGW = REGW_DEFAULT,
  parameter int CNTW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [SELW-1:0]      src_sel,
  input  logic [REGW-1:0]      rd_in,
  input  logic                 we_in,
  input  logic                 valid_in,
  input  logic                 stall,
  input  logic                 flush,
`ifdef WB_BYPASS_EN
  output logic [XLEN-1:0]      byp_data,
  output logic [REGW-1:0]      byp_addr,
  output logic                 byp_valid,
`endif
  output logic [XLEN-1:0]      wd3,
  output logic [REGW-1:0]      wa3,
  output logic                 we3,
  output logic                 valid_out,
  output logic [CNTW-1:0]      wb_count
);

  logic [XLEN-1:0] mux_data;
  logic            mux_in_range;
  logic            we_next;

  wb_src_mux #(
    .XLEN(XLEN),
    .NSRC(NSRC),
    .SELW(SELW)
  ) u_mux (
    .src_data(src_data),
    .sel     (src_sel),
    .data    (mux_data),
    .in_range(mux_in_range)
  );

  // x0 and illegal selects still load data/address but never write
  assign we_next = valid_in & we_in & (rd_in != '0) & mux_in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd3       <= '0;
      wa3       <= '0;
      we3       <= 1'b0;
      valid_out <= 1'b0;
      wb_count  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      we3       <= 1'b0;
    end else if (stall) begin
      // held instruction must not write the register file twice
      we3 <= 1'b0;
    end else begin
      wd3       <= mux_data;
      wa3       <= rd_in;
      valid_out <= valid_in;
      we3       <= we_next;
      if (we_next) begin
        wb_count <= wb_count + CNTW'(1);
      end
    end
  end

`ifdef WB_BYPASS_EN
  // captures the write that just retired; independent of stall/flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_data  <= '0;
      byp_addr  <= '0;
      byp_valid <= 1'b0;
    end else if (we3) begin
      byp_data  <= wd3;
      byp_addr  <= wa3;
      byp_valid <= 1'b1;
    end else begin
      byp_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised successor to the 2:1 writeback-source mux.
- Selects one of NSRC writeback sources (ALU, load data, PC+4, LUI immediate, ...) and registers it as the MEM/WB pipeline register.
- Drives the register-file write port: WD3, write address, write enable.
- Adds stall, flush, x0 write suppression, illegal-select protection and a retired-write counter.

Parameters:
- XLEN, 32, data width of each source and of wd3.
- NSRC, 4, number of writeback sources (>=2).
- SELW, $clog2(NSRC), width of the source select.
- REGW, 5, register address width.
- CNTW, 32, width of the retired-write counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- src_data  in  NSRC*XLEN  flattened sources; source i occupies bits [i*XLEN +: XLEN].
- src_sel  in  SELW  source index from CU.
- rd_in  in  REGW  destination register.
- we_in  in  1  register write request from CU.
- valid_in  in  1  instruction in MEM is valid.
- stall  in  1  hold the WB register.
- flush  in  1  kill the incoming instruction.
- wd3  out  XLEN  registered write data.
- wa3  out  REGW  registered write address.
- we3  out  1  registered write enable.
- valid_out  out  1  WB stage holds a valid instruction.
- wb_count  out  CNTW  number of register writes issued.

Behaviour:
- Clocking and reset: one clock domain, clk. rst_n is sampled only at the rising edge of clk (synchronous, active-low).
- Latency: inputs sampled at edge N appear on the outputs after edge N. Exactly one cycle.
- Priority at each edge: reset > flush > stall > load.
- Reset (rst_n=0): wd3=0, wa3=0, we3=0, valid_out=0, wb_count=0. The bypass registers (if present) are also 0.
- Flush: valid_out<=0 and we3<=0. wd3 and wa3 hold. wb_count holds. Flush wins over a simultaneous stall.
- Stall:
  - wd3, wa3 and valid_out hold.
  - we3<=0, so a held write is never repeated.
  - wb_count holds.
- Load (no reset, flush or stall):
  - wd3 <= src_data[src_sel], or 0 when src_sel>=NSRC.
  - wa3 <= rd_in.
  - valid_out <= valid_in.
  - we3 <= valid_in & we_in & (rd_in!=0) & (src_sel<NSRC).
- Counter: wb_count increments by 1 at every edge where we3 is loaded as 1. It wraps modulo 2^CNTW with no saturation.
- x0 writes: rd_in==0 loads data and address normally, but we3 is forced to 0.
- Combinational paths: the source mux is purely combinational. No output depends combinationally on any input.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs byp_data (XLEN), byp_addr (REGW) and byp_valid (1).
  - These form a one-entry history register, loaded with {wd3, wa3, we3} at every edge where we3 is 1.
  - byp_valid clears on the next edge where we3 is 0. Flush and stall do not clear it.
  - Purpose: the ID stage covers the WB-to-ID read-after-write case one cycle after the write.
- Not defined: ports and registers are absent. All other behaviour is identical.

Decomposition:
- Package wb_pkg:
  - XLEN and REGW defaults.
  - Source index constants SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_IMM=3.
  - Localparam NSRC_DEFAULT=4.
- Sub-module wb_src_mux: combinational NSRC:1 mux with out-of-range-to-zero and an in_range flag. It is instantiated once; the stage adds the registers, control and counter.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with valid_in=1, we_in=1 -> all outputs 0. Release with src_sel=3, src_data[3]=32'h12345000, rd_in=5 -> next cycle wd3=32'h12345000, wa3=5, we3=1, wb_count=1.
- Sweep src_sel 0..3 with distinct sources 32'hA0, 32'hB1, 32'hC2, 32'hD3 and rd_in=7 -> wd3 follows with 1-cycle latency, we3=1 each cycle, wb_count=4.
- rd_in=0, we_in=1, src_data[0]=32'hFFFF_FFFF -> wd3=32'hFFFF_FFFF, we3=0, wb_count unchanged.
- Load a write to rd=9, then stall=1 for 3 cycles -> wd3/wa3/valid_out held, we3=1 only in the first cycle, wb_count +1 total.
- stall=1 and flush=1 together -> valid_out=0, we3=0, wd3 holds. A separate case with NSRC=3 and src_sel=3 -> wd3=0, we3=0.
- WB_BYPASS_EN: write rd=4 data 32'h55 followed by a bubble -> byp_data=32'h55, byp_addr=4, byp_valid=1 for one cycle, then 0. Preload wb_count to 2^CNTW-1 via the CNTW=4 build and write once -> count wraps to 0.
